seq_loader_avalon: RTL and testbench
====================================

// Module: seq_loader_avalon
// PURPOSE
//  Avalon-MM front end upstream of short_solver: CPU writes seq1/seq2 as packed 2-bit bases,
//  then a START command. Block holds seq registers stable, sequences solver reset,
//  runs solver to finished, and reports status, run-cycle count and errors.
// PARAMETERS
//  LEN1        10    bases in seq1 (1..32)
//  LEN2        9     bases in seq2 (1..32)
//  RST_CYCLES  2     cycles solver_rst held high before RUN (>=1)
//  TIMEOUT     4096  max RUN cycles before abort with error
// PORTS
//  clk                  in   1       system clock; single clock domain
//  rst                  in   1       synchronous, active-high reset
//  avm_main_address     in   6       64-bit word index
//  avm_main_byteenable  in   8       per-byte write enable
//  avm_main_read        in   1       read request
//  avm_main_readdata    out  64      read data, combinational from address
//  avm_main_write       in   1       write request
//  avm_main_writedata   in   64      write data
//  seq1                 out  LEN1x2  dna_base [0:LEN1-1], stable while busy
//  seq2                 out  LEN2x2  dna_base [0:LEN2-1], stable while busy
//  solver_rst           out  1       reset to short_solver
//  solver_finished      in   1       short_solver finished flag
// BEHAVIOUR
//  Register map (word addr): 0 CTRL (W), 1 STATUS (R), 2 CYCLES (R), 4 SEQ1 (R/W), 5 SEQ2 (R/W).
//  SEQn: base i at bits [2i+1:2i], cast directly to dna_base; bits above 2*LENn ignored/read 0.
//  SEQn writes honour byteenable per byte; any write to SEQn sets loaded_n=1.
//  CTRL bit0 START, bit1 ABORT; self-clearing commands, byteenable[0] required.
//  STATUS: bit0 busy, bit1 done, bit2 err_notloaded, bit3 err_busywrite, bit4 err_timeout, bits[7:5]=state.
//  Reads: zero latency, no waitrequest; unmapped addresses return 64'h0. Reads have no side effects.
//  FSM: IDLE -> RSTQ -> RUN -> DONE.
//   IDLE: solver_rst=1. START with loaded_1&&loaded_2 -> RSTQ, clear done/err bits, CYCLES=0;
//         START without both loaded -> stay IDLE, set err_notloaded.
//   RSTQ: solver_rst=1 for exactly RST_CYCLES cycles (counter), then RUN.
//   RUN:  solver_rst=0; CYCLES+=1 each cycle; solver_finished=1 -> DONE (CYCLES includes that cycle);
//         CYCLES reaching TIMEOUT without finished -> IDLE, err_timeout=1.
//   DONE: solver_rst=0 (results held for downstream readout); done=1; START -> RSTQ (rerun).
//  busy=1 in RSTQ and RUN. SEQ writes while busy are dropped and set err_busywrite.
//  ABORT in any state -> IDLE next cycle, solver_rst=1, done=0; seq/loaded flags kept. ABORT beats START.
//  Write to CTRL and SEQn never occur same cycle (one address); START same cycle as SEQ write impossible.
//  CYCLES is 32-bit, saturates at 2^32-1 (unreachable with legal TIMEOUT).
//  Error bits sticky until next accepted START or rst.
//  Reset: state=IDLE, solver_rst=1, seq1/seq2=all-zero code, loaded_n=0, CYCLES=0,
//   all STATUS bits 0, readdata follows address (0 for unmapped). Reset mid-RUN aborts same way.
// TESTING
//  1 Write SEQ1=ATCAGTTGGA, SEQ2=GGCATTGTA, START -> solver_rst high 2 cycles, low in RUN; done=1, CYCLES>0.
//  2 START after rst with no SEQ writes -> STATUS=0x04, state IDLE, solver_rst stays 1.
//  3 SEQ1 write with byteenable=8'h01 -> only bases 0..3 change; readback of SEQ1 confirms.
//  4 SEQ2 write during RUN -> seq2 unchanged, err_busywrite=1, run completes normally.
//  5 Tie solver_finished=0, TIMEOUT=16 -> after 16 RUN cycles STATUS.err_timeout=1, busy=0, CYCLES=16.
//  6 ABORT mid-RUN then START -> restarts from RSTQ, CYCLES cleared, errors cleared; rst mid-RSTQ -> all reset values.

Source files
------------

// File: rtl/seq_loader_avalon.sv
// seq_loader_avalon: Avalon-MM register front end for short_solver.
// Holds two packed 2-bit base sequences, drives the solver reset sequence,
// times the solver run and reports status, run length and sticky errors
// through a small 64-bit register map with zero-latency reads.
module seq_loader_avalon #(
    parameter int LEN1       = 10,
    parameter int LEN2       = 9,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        avm_main_address,
    input  logic [7:0]        avm_main_byteenable,
    input  logic              avm_main_read,
    output logic [63:0]       avm_main_readdata,
    input  logic              avm_main_write,
    input  logic [63:0]       avm_main_writedata,
    output logic [2*LEN1-1:0] seq1,
    output logic [2*LEN2-1:0] seq2,
    output logic              solver_rst,
    input  logic              solver_finished
);

    // State codes are visible in STATUS[7:5], so the encoding is fixed.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RSTQ = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3
    } state_t;

    localparam logic [5:0]  A_CTRL    = 6'd0;
    localparam logic [5:0]  A_STATUS  = 6'd1;
    localparam logic [5:0]  A_CYCLES  = 6'd2;
    localparam logic [5:0]  A_SEQ1    = 6'd4;
    localparam logic [5:0]  A_SEQ2    = 6'd5;
    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    state_t            state_q;
    logic [2*LEN1-1:0] seq1_q, seq1_d;
    logic [2*LEN2-1:0] seq2_q, seq2_d;
    logic              loaded1_q, loaded2_q;
    logic              done_q;
    logic              err_notloaded_q, err_busywrite_q, err_timeout_q;
    logic              solver_rst_q;
    logic [15:0]       rst_cnt_q;
    logic [31:0]       cycles_q, cycles_inc;
    logic              wr_ctrl, start_cmd, abort_cmd, wr_seq1, wr_seq2, busy;
    logic [63:0]       rdata;

    // The read strobe is not needed: reads are combinational and side-effect free.
    logic unused_inputs;
    assign unused_inputs = ^{avm_main_read, avm_main_writedata};

    // Decode this cycle's bus write into commands and sequence updates
    always_comb begin
        // NOTE: every signal written in always_comb is given a value on every path, otherwise a latch is inferred.
        wr_ctrl    = avm_main_write && (avm_main_address == A_CTRL) && avm_main_byteenable[0];
        start_cmd  = wr_ctrl && avm_main_writedata[0];
        abort_cmd  = wr_ctrl && avm_main_writedata[1];
        wr_seq1    = avm_main_write && (avm_main_address == A_SEQ1);
        wr_seq2    = avm_main_write && (avm_main_address == A_SEQ2);
        busy       = (state_q == S_RSTQ) || (state_q == S_RUN);
        cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
    end

    // Merge write data into the held sequences base by base, honouring byteenable
    always_comb begin
        seq1_d = seq1_q;
        seq2_d = seq2_q;
        for (int i = 0; i < LEN1; i++) begin
            if (avm_main_byteenable[i / 4]) seq1_d[2*i +: 2] = avm_main_writedata[2*i +: 2];
        end
        for (int i = 0; i < LEN2; i++) begin
            if (avm_main_byteenable[i / 4]) seq2_d[2*i +: 2] = avm_main_writedata[2*i +: 2];
        end
    end

    // Control FSM plus all register-map state, with registered solver reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q         <= S_IDLE;
            seq1_q          <= '0;
            seq2_q          <= '0;
            loaded1_q       <= 1'b0;
            loaded2_q       <= 1'b0;
            done_q          <= 1'b0;
            err_notloaded_q <= 1'b0;
            err_busywrite_q <= 1'b0;
            err_timeout_q   <= 1'b0;
            solver_rst_q    <= 1'b1;
            rst_cnt_q       <= '0;
            cycles_q        <= '0;
        end else begin
            // Sequence writes are frozen while the solver is working on them.
            if (wr_seq1) begin
                if (busy) begin
                    err_busywrite_q <= 1'b1;
                end else begin
                    seq1_q    <= seq1_d;
                    loaded1_q <= 1'b1;
                end
            end
            if (wr_seq2) begin
                if (busy) begin
                    err_busywrite_q <= 1'b1;
                end else begin
                    seq2_q    <= seq2_d;
                    loaded2_q <= 1'b1;
                end
            end

            if (abort_cmd) begin
                // Abort wins over start and over any run-state transition.
                state_q      <= S_IDLE;
                solver_rst_q <= 1'b1;
                done_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_cmd) begin
                            if (loaded1_q && loaded2_q) begin
                                state_q         <= S_RSTQ;
                                solver_rst_q    <= 1'b1;
                                rst_cnt_q       <= '0;
                                cycles_q        <= '0;
                                done_q          <= 1'b0;
                                err_notloaded_q <= 1'b0;
                                err_busywrite_q <= 1'b0;
                                err_timeout_q   <= 1'b0;
                            end else begin
                                err_notloaded_q <= 1'b1;
                            end
                        end
                    end
                    S_RSTQ: begin
                        if (rst_cnt_q == RST_LAST) begin
                            state_q      <= S_RUN;
                            solver_rst_q <= 1'b0;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + 16'd1;
                        end
                    end
                    S_RUN: begin
                        cycles_q <= cycles_inc;
                        if (solver_finished) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (cycles_inc >= TIMEOUT_W) begin
                            state_q       <= S_IDLE;
                            solver_rst_q  <= 1'b1;
                            err_timeout_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q      <= S_IDLE;
                        solver_rst_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Zero-latency read mux; unmapped and write-only words read as zero
    always_comb begin
        rdata = '0;
        case (avm_main_address)
            A_STATUS: rdata[7:0] = {state_q, err_timeout_q, err_busywrite_q,
                                    err_notloaded_q, done_q, busy};
            A_CYCLES: rdata[31:0] = cycles_q;
            A_SEQ1:   rdata[2*LEN1-1:0] = seq1_q;
            A_SEQ2:   rdata[2*LEN2-1:0] = seq2_q;
            default:  rdata = '0;
        endcase
    end

    assign avm_main_readdata = rdata;
    assign seq1              = seq1_q;
    assign seq2              = seq2_q;
    assign solver_rst        = solver_rst_q;

endmodule

// File: tb/tb_seq_loader_avalon.sv
// tb_seq_loader_avalon: randomized and directed bench for seq_loader_avalon.
// A small solver model answers after a chosen number of run cycles; a
// run-timeline reference model predicts register contents; reads are
// checked by a scoreboard monitor.
module tb_seq_loader_avalon;

    localparam int LEN1       = 10;
    localparam int LEN2       = 9;
    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 16;

    localparam int S_IDLE = 0;
    localparam int S_RSTQ = 1;
    localparam int S_RUN  = 2;
    localparam int S_DONE = 3;

    localparam logic [5:0] A_CTRL   = 6'd0;
    localparam logic [5:0] A_STATUS = 6'd1;
    localparam logic [5:0] A_CYCLES = 6'd2;
    localparam logic [5:0] A_SEQ1   = 6'd4;
    localparam logic [5:0] A_SEQ2   = 6'd5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [5:0]        avm_main_address = '0;
    logic [7:0]        avm_main_byteenable = '0;
    logic              avm_main_read = 1'b0;
    logic [63:0]       avm_main_readdata;
    logic              avm_main_write = 1'b0;
    logic [63:0]       avm_main_writedata = '0;
    logic [2*LEN1-1:0] seq1;
    logic [2*LEN2-1:0] seq2;
    logic              solver_rst;
    logic              solver_finished = 1'b0;

    seq_loader_avalon #(
        .LEN1(LEN1), .LEN2(LEN2), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .avm_main_address(avm_main_address),
        .avm_main_byteenable(avm_main_byteenable),
        .avm_main_read(avm_main_read),
        .avm_main_readdata(avm_main_readdata),
        .avm_main_write(avm_main_write),
        .avm_main_writedata(avm_main_writedata),
        .seq1(seq1),
        .seq2(seq2),
        .solver_rst(solver_rst),
        .solver_finished(solver_finished)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Solver model: raises finished on the solver_lat-th cycle after its reset drops.
    int solver_lat = 0;
    int run_cnt    = 0;
    always @(negedge clk) begin
        if (solver_rst !== 1'b0) run_cnt = 0;
        else run_cnt = run_cnt + 1;
        solver_finished = (solver_lat != 0) && (run_cnt == solver_lat);
    end

    // ---------------- reference model ----------------
    typedef struct {
        int state;
        int cycles;
        bit done;
        bit err_to;
        bit cyc_known;
    } view_t;

    logic [1:0]  m_seq1 [LEN1];
    logic [1:0]  m_seq2 [LEN2];
    bit          m_l1, m_l2, m_err_nl, m_err_bw;
    bit          m_run;
    int unsigned m_c0;
    int          m_lat;
    view_t       m_st;

    task automatic model_reset();
        foreach (m_seq1[i]) m_seq1[i] = 2'b00;
        foreach (m_seq2[i]) m_seq2[i] = 2'b00;
        m_l1 = 0; m_l2 = 0; m_err_nl = 0; m_err_bw = 0;
        m_run = 0; m_c0 = 0; m_lat = 0;
        m_st.state = S_IDLE; m_st.cycles = 0; m_st.done = 0;
        m_st.err_to = 0; m_st.cyc_known = 1;
    endtask

    // Where an accepted run stands n edges after the START edge.
    function automatic view_t view_at(input int unsigned c);
        view_t v;
        int n, m;
        if (!m_run) return m_st;
        n = int'(c - m_c0);
        v.done = 0; v.err_to = 0; v.cyc_known = 1; v.cycles = 0;
        if (n < RST_CYCLES) begin
            v.state = S_RSTQ;
        end else begin
            m = n - RST_CYCLES;
            if (m_lat >= 1 && m >= m_lat) begin
                v.state = S_DONE; v.cycles = m_lat; v.done = 1;
            end else if (m >= TIMEOUT) begin
                v.state = S_IDLE; v.cycles = TIMEOUT; v.err_to = 1;
            end else begin
                v.state = S_RUN; v.cycles = m;
            end
        end
        return v;
    endfunction

    function automatic bit is_busy(input view_t v);
        return (v.state == S_RSTQ) || (v.state == S_RUN);
    endfunction

    function automatic logic [63:0] seq_word(input int which);
        logic [63:0] w;
        w = '0;
        if (which == 1) begin
            for (int i = 0; i < LEN1; i++) w[2*i +: 2] = m_seq1[i];
        end else begin
            for (int i = 0; i < LEN2; i++) w[2*i +: 2] = m_seq2[i];
        end
        return w;
    endfunction

    function automatic logic [63:0] exp_status(input view_t v);
        logic [63:0] s;
        s = '0;
        s[0]   = is_busy(v);
        s[1]   = v.done;
        s[2]   = m_err_nl;
        s[3]   = m_err_bw;
        s[4]   = v.err_to;
        s[7:5] = 3'(v.state);
        return s;
    endfunction

    function automatic logic [63:0] exp_read(input logic [5:0] a, input view_t v, output bit care);
        logic [63:0] r;
        care = 1'b1;
        case (a)
            A_STATUS: r = exp_status(v);
            A_CYCLES: begin r = 64'(v.cycles); care = v.cyc_known; end
            A_SEQ1:   r = seq_word(1);
            A_SEQ2:   r = seq_word(2);
            default:  r = '0;
        endcase
        return r;
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be,
                               input view_t v, input int unsigned c);
        if (a == A_CTRL && be[0]) begin
            if (d[1]) begin
                m_st.state = S_IDLE; m_st.done = 0; m_st.err_to = v.err_to;
                m_st.cycles = 0; m_st.cyc_known = 0;
                m_run = 0;
            end else if (d[0] && (v.state == S_IDLE || v.state == S_DONE)) begin
                if (m_l1 && m_l2) begin
                    m_run = 1; m_c0 = c; m_lat = solver_lat;
                    m_err_nl = 0; m_err_bw = 0;
                end else begin
                    m_err_nl = 1;
                end
            end
        end else if (a == A_SEQ1) begin
            if (is_busy(v)) m_err_bw = 1;
            else begin
                for (int i = 0; i < LEN1; i++) if (be[i/4]) m_seq1[i] = d[2*i +: 2];
                m_l1 = 1;
            end
        end else if (a == A_SEQ2) begin
            if (is_busy(v)) m_err_bw = 1;
            else begin
                for (int i = 0; i < LEN2; i++) if (be[i/4]) m_seq2[i] = d[2*i +: 2];
                m_l2 = 1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [63:0] exp;
        bit          care;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (avm_main_read === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: read of address %0d had no expectation", avm_main_address);
            end else begin
                e = sb.pop_front();
                if (e.care) check(e.name, avm_main_readdata, e.exp);
            end
        end
    end

    // ---------------- bus and port tasks (each starts 1 time unit after an edge) ----------------
    task automatic check_ports();
        view_t v;
        v = view_at(cyc);
        check("solver_rst", solver_rst, (v.state == S_IDLE || v.state == S_RSTQ) ? 64'd1 : 64'd0);
        check("seq1_port", seq1, seq_word(1));
        check("seq2_port", seq2, seq_word(2));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check_ports();
        end
    endtask

    task automatic push_exp(input string name, input logic [63:0] exp, input bit care);
        exp_t e;
        e.name = name; e.exp = exp; e.care = care;
        sb.push_back(e);
    endtask

    task automatic bus_read(input logic [5:0] a);
        bit care;
        logic [63:0] exp;
        exp = exp_read(a, view_at(cyc), care);
        push_exp($sformatf("read_a%0d", a), exp, care);
        avm_main_address = a; avm_main_read = 1'b1;
        @(posedge clk); #1;
        avm_main_read = 1'b0;
        check_ports();
    endtask

    task automatic bus_read_lit(input logic [5:0] a, input logic [63:0] exp, input string name);
        push_exp(name, exp, 1'b1);
        avm_main_address = a; avm_main_read = 1'b1;
        @(posedge clk); #1;
        avm_main_read = 1'b0;
        check_ports();
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be);
        view_t v;
        v = view_at(cyc);
        avm_main_address = a; avm_main_writedata = d; avm_main_byteenable = be;
        avm_main_write = 1'b1;
        @(posedge clk); #1;
        avm_main_write = 1'b0;
        model_write(a, d, be, v, cyc);
        check_ports();
    endtask

    task automatic start_run(input int lat);
        solver_lat = lat;
        bus_write(A_CTRL, 64'h1, 8'h01);
    endtask

    task automatic finish_run();
        idle(RST_CYCLES + TIMEOUT + 2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_ports();
    endtask

    function automatic logic [63:0] pack_str(input string s);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "A": w[2*i +: 2] = 2'd0;
                "C": w[2*i +: 2] = 2'd1;
                "G": w[2*i +: 2] = 2'd2;
                default: w[2*i +: 2] = 2'd3;
            endcase
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] s1, s2, d;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_ports();

        // Reset state
        bus_read_lit(A_STATUS, 64'h0, "rst_status");
        bus_read_lit(A_CYCLES, 64'h0, "rst_cycles");
        bus_read_lit(A_SEQ1, 64'h0, "rst_seq1");
        bus_read_lit(A_SEQ2, 64'h0, "rst_seq2");
        bus_read_lit(6'd3, 64'h0, "rst_unmapped3");
        bus_read_lit(6'd63, 64'h0, "rst_unmapped63");

        // START with nothing loaded
        start_run(5);
        bus_read_lit(A_STATUS, 64'h04, "notloaded_status");
        idle(3);

        // Directed run with the reference sequences
        s1 = pack_str("ATCAGTTGGA");
        s2 = pack_str("GGCATTGTA");
        bus_write(A_SEQ1, s1, 8'hFF);
        bus_write(A_SEQ2, s2, 8'hFF);
        check("t1_seq1_port", seq1, s1);
        check("t1_seq2_port", seq2, s2);
        bus_read_lit(A_SEQ1, s1, "t1_seq1_rb");
        start_run(int'($urandom_range(1, 12)));
        bus_read_lit(A_STATUS, 64'h21, "t1_rstq_status");
        finish_run();
        bus_read_lit(A_STATUS, 64'h62, "t1_done_status");
        bus_read(A_CYCLES);

        // Byteenable 0x01 on SEQ1 touches bases 0..3 only
        d = {$urandom, $urandom};
        bus_write(A_SEQ1, d, 8'h01);
        bus_read_lit(A_SEQ1, (s1 & ~64'hFF) | (d & 64'hFF), "t3_be01_rb");

        // SEQ2 write during RUN is dropped
        start_run(12);
        idle(4);
        bus_write(A_SEQ2, {$urandom, $urandom}, 8'hFF);
        check("t4_seq2_held", seq2, s2);
        bus_read_lit(A_STATUS, 64'h49, "t4_busy_status");
        finish_run();
        bus_read_lit(A_STATUS, 64'h6A, "t4_done_status");
        bus_read_lit(A_CYCLES, 64'd12, "t4_cycles");

        // Timeout, and finishing exactly on the last allowed cycle
        start_run(0);
        finish_run();
        bus_read_lit(A_STATUS, 64'h10, "t5_timeout_status");
        bus_read_lit(A_CYCLES, 64'd16, "t5_timeout_cycles");
        start_run(TIMEOUT);
        finish_run();
        bus_read_lit(A_STATUS, 64'h62, "t5_edge_status");
        bus_read_lit(A_CYCLES, 64'd16, "t5_edge_cycles");

        // ABORT mid-run, then restart
        start_run(10);
        idle(RST_CYCLES + 3);
        bus_read(A_STATUS);
        bus_write(A_CTRL, 64'h2, 8'h01);
        bus_read_lit(A_STATUS, 64'h00, "t6_abort_status");
        start_run(7);
        bus_read_lit(A_STATUS, 64'h21, "t6_restart_status");
        bus_read_lit(A_CYCLES, 64'h0, "t6_restart_cycles");
        finish_run();
        bus_read_lit(A_CYCLES, 64'd7, "t6_rerun_cycles");

        // ABORT and START together: abort wins
        start_run(10);
        idle(3);
        bus_write(A_CTRL, 64'h3, 8'h01);
        bus_read_lit(A_STATUS, 64'h00, "t6_abort_beats_start");

        // START without byteenable[0] is ignored
        bus_write(A_CTRL, 64'h1, 8'hFE);
        bus_read_lit(A_STATUS, 64'h00, "ctrl_be_gated");

        // Reset in the middle of RSTQ
        start_run(5);
        do_reset();
        bus_read_lit(A_STATUS, 64'h0, "t6_rst_status");
        bus_read_lit(A_CYCLES, 64'h0, "t6_rst_cycles");
        bus_read_lit(A_SEQ1, 64'h0, "t6_rst_seq1");
        bus_read_lit(A_SEQ2, 64'h0, "t6_rst_seq2");
        start_run(5);
        bus_read_lit(A_STATUS, 64'h04, "t6_rst_notloaded");

        // Randomized traffic against the model
        bus_write(A_SEQ1, {$urandom, $urandom}, 8'hFF);
        bus_write(A_SEQ2, {$urandom, $urandom}, 8'hFF);
        for (int it = 0; it < 250; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1: bus_write((op == 0) ? A_SEQ1 : A_SEQ2, {$urandom, $urandom}, 8'($urandom));
                2: bus_read(6'($urandom_range(0, 7)));
                3: bus_read(6'($urandom));
                4: begin
                    if (is_busy(view_at(cyc))) idle(1);
                    else begin
                        solver_lat = int'($urandom_range(0, TIMEOUT));
                        d = {$urandom, $urandom};
                        bus_write(A_CTRL, {d[63:2], 2'b01}, 8'($urandom) | 8'h01);
                    end
                end
                5: begin
                    if ($urandom_range(0, 2) == 0) bus_write(A_CTRL, 64'($urandom_range(2, 3)), 8'h01);
                    else bus_read(A_STATUS);
                end
                6: bus_write(A_CTRL, 64'h3, 8'($urandom) & 8'hFE);
                default: idle(int'($urandom_range(1, 6)));
            endcase
        end

        idle(2);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
